// File: rtl/seg7_msg_display.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg7_msg_display: NDIG-digit active-low 7-segment driver showing a
// MSG_LEN-entry message buffer in static, blink or scroll mode.
// Rev 1.0
// ----------------------------------------------------------------------------
module seg7_msg_display #(
  parameter int NDIG    = 4,
  parameter int MSG_LEN = 8,
  parameter int DIV     = 4,
  parameter int DIV_W   = 24,
  localparam int AW     = $clog2(MSG_LEN)
) (
  input  logic              ck,
  input  logic              rs_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [6:0]        wr_data,
  output logic [7*NDIG-1:0] hex,
  output logic              tick
);

  localparam logic [1:0]       MODE_BLINK  = 2'b01;
  localparam logic [1:0]       MODE_SCROLL = 2'b10;
  localparam logic [0:0]       ST_SHOW     = 1'b0;
  localparam logic [0:0]       ST_BLANK    = 1'b1;
  localparam logic [6:0]       C_SEG_OFF   = 7'h7F;
  localparam logic [DIV_W-1:0] C_CNT_MAX   = DIV_W'(DIV - 1);
  localparam logic [AW:0]      C_LEN       = (AW+1)'(MSG_LEN);
  localparam logic [AW-1:0]    C_OFF_MAX   = AW'(MSG_LEN - 1);

  logic [DIV_W-1:0] r_count;
  logic [1:0]       r_mode_q;
  logic [AW-1:0]    r_offset;
  logic [0:0]       r_state;
  logic [0:0]       w_state_next;
  logic             w_blank;
  logic [6:0]       r_msg [MSG_LEN];
  logic             w_mode_chg;
  logic             w_wrap;
  logic [AW-1:0]    w_base;
  logic [AW:0]      w_idx;
  logic [7*NDIG-1:0] w_hex_next;

  // A mode change owns its edge: it restarts the prescaler and swallows any wrap.
  assign w_mode_chg = (mode != r_mode_q);
  assign w_wrap     = en && !w_mode_chg && (r_count == C_CNT_MAX);

  always_ff @(posedge ck or negedge rs_n) begin
    if (!rs_n) begin
      r_count  <= '0;
      tick     <= 1'b0;
      r_mode_q <= 2'b00;
      r_offset <= '0;
    end else begin
      r_mode_q <= mode;
      tick     <= w_wrap;
      if (w_mode_chg) begin
        r_count  <= '0;
        r_offset <= '0;
      end else begin
        if (en)
          r_count <= w_wrap ? '0 : r_count + 1'b1;
        if (w_wrap && (r_mode_q == MODE_SCROLL))
          r_offset <= (r_offset == C_OFF_MAX) ? '0 : r_offset + 1'b1;
      end
    end
  end

  always_ff @(posedge ck or negedge rs_n) begin
    if (!rs_n)
      r_state <= ST_SHOW;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_mode_chg || (r_mode_q != MODE_BLINK))
      w_state_next = ST_SHOW;
    else if (w_wrap)
      w_state_next = (r_state == ST_SHOW) ? ST_BLANK : ST_SHOW;
  end

  always_comb begin
    w_blank = (r_mode_q == MODE_BLINK) && (r_state == ST_BLANK);
  end

  always_ff @(posedge ck or negedge rs_n) begin
    if (!rs_n) begin
      for (int i = 0; i < MSG_LEN; i++)
        r_msg[i] <= C_SEG_OFF;
    end else if (wr_en && ({1'b0, wr_addr} < C_LEN)) begin
      r_msg[wr_addr] <= wr_data;
    end
  end

  // offset < MSG_LEN and i < NDIG <= MSG_LEN, so one conditional subtract wraps.
  assign w_base = (r_mode_q == MODE_SCROLL) ? r_offset : '0;

  always_comb begin
    w_hex_next = '0;
    w_idx      = '0;
    for (int i = 0; i < NDIG; i++) begin
      w_idx = {1'b0, w_base} + (AW+1)'(i);
      if (w_idx >= C_LEN)
        w_idx = w_idx - C_LEN;
      w_hex_next[7*(NDIG-1-i) +: 7] = w_blank ? C_SEG_OFF : r_msg[w_idx[AW-1:0]];
    end
  end

  always_ff @(posedge ck or negedge rs_n) begin
    if (!rs_n)
      hex <= '1;
    else
      hex <= w_hex_next;
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_msg_display.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_seg7_msg_display: directed self-checking bench for seg7_msg_display.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_seg7_msg_display;

  localparam logic [27:0] ALL_OFF = 28'hFFFFFFF;
  localparam logic [6:0]  NEWC    = 7'h55;

  logic        ck = 1'b0;
  logic        rs_n;
  logic        en, wr_en;
  logic [1:0]  mode;
  logic [2:0]  wr_addr;
  logic [6:0]  wr_data;
  logic [27:0] hex;
  logic        tick;

  logic        en6, wr_en6;
  logic [1:0]  mode6;
  logic [2:0]  wr_addr6;
  logic [6:0]  wr_data6;
  logic [27:0] hex6;
  logic        tick6;

  int total = 0;
  int bad   = 0;
  logic [6:0] code [8];

  always #5 ck = ~ck;

  seg7_msg_display #(.NDIG(4), .MSG_LEN(8), .DIV(4), .DIV_W(24)) u_dut (
    .ck(ck), .rs_n(rs_n), .en(en), .mode(mode), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .hex(hex), .tick(tick)
  );

  // Non-power-of-two buffer: lets out-of-range addresses and modulo-6 wrap be exercised.
  seg7_msg_display #(.NDIG(4), .MSG_LEN(6), .DIV(4), .DIV_W(24)) u_dut6 (
    .ck(ck), .rs_n(rs_n), .en(en6), .mode(mode6), .wr_en(wr_en6),
    .wr_addr(wr_addr6), .wr_data(wr_data6), .hex(hex6), .tick(tick6)
  );

  function automatic logic [27:0] show4(input int a, input int b, input int c, input int d);
    return {code[a], code[b], code[c], code[d]};
  endfunction

  task automatic test_reset;
    rs_n = 1'b1; en = 1'b0; mode = 2'b00; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    en6 = 1'b0; mode6 = 2'b00; wr_en6 = 1'b0; wr_addr6 = '0; wr_data6 = '0;
    #2 rs_n = 1'b0;
    #1;
    total++;
    if (hex !== ALL_OFF) begin bad++; $display("FAIL reset_hex got=%h want=%h", hex, ALL_OFF); end
    total++;
    if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", tick); end
    @(negedge ck);
    rs_n = 1'b1;
    repeat (3) @(negedge ck);
    total++;
    if (hex !== ALL_OFF) begin bad++; $display("FAIL reset_empty_static got=%h want=%h", hex, ALL_OFF); end
  endtask

  task automatic test_static;
    for (int k = 0; k < 8; k++) begin
      wr_en = 1'b1; wr_addr = 3'(k); wr_data = code[k];
      @(negedge ck);
    end
    wr_en = 1'b0;
    @(negedge ck);
    total++;
    if (hex !== show4(0, 1, 2, 3)) begin bad++; $display("FAIL static_hex got=%h want=%h", hex, show4(0, 1, 2, 3)); end
    en = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge ck);
      total++;
      if (tick !== ((c % 4) == 0)) begin bad++; $display("FAIL static_tick c=%0d got=%b want=%b", c, tick, ((c % 4) == 0)); end
      total++;
      if (hex !== show4(0, 1, 2, 3)) begin bad++; $display("FAIL static_hold c=%0d got=%h want=%h", c, hex, show4(0, 1, 2, 3)); end
    end
    en = 1'b0;
  endtask

  task automatic test_blink;
    logic [27:0] exp;
    mode = 2'b01; en = 1'b1;
    @(negedge ck);
    total++;
    if (tick !== 1'b0) begin bad++; $display("FAIL blink_modechg_tick got=%b want=0", tick); end
    for (int c = 1; c <= 12; c++) begin
      @(negedge ck);
      exp = (((c - 1) / 4) % 2 == 1) ? ALL_OFF : show4(0, 1, 2, 3);
      total++;
      if (hex !== exp) begin bad++; $display("FAIL blink_hex c=%0d got=%h want=%h", c, hex, exp); end
      total++;
      if (tick !== ((c % 4) == 0)) begin bad++; $display("FAIL blink_tick c=%0d got=%b want=%b", c, tick, ((c % 4) == 0)); end
    end
    en = 1'b0;
    for (int c = 13; c <= 20; c++) begin
      @(negedge ck);
      total++;
      if (hex !== ALL_OFF) begin bad++; $display("FAIL blink_freeze c=%0d got=%h want=%h", c, hex, ALL_OFF); end
      total++;
      if (tick !== 1'b0) begin bad++; $display("FAIL blink_freeze_tick c=%0d got=%b want=0", c, tick); end
    end
  endtask

  task automatic test_scroll;
    logic [27:0] exp;
    logic        chk;
    mode = 2'b10; en = 1'b1;
    @(negedge ck);
    for (int c = 1; c <= 33; c++) begin
      @(negedge ck);
      chk = 1'b1;
      exp = '0;
      case (c)
        1:       exp = show4(0, 1, 2, 3);
        5:       exp = show4(1, 2, 3, 4);
        21:      exp = show4(5, 6, 7, 0);
        29:      exp = show4(7, 0, 1, 2);
        33:      exp = show4(0, 1, 2, 3);
        default: chk = 1'b0;
      endcase
      if (chk) begin
        total++;
        if (hex !== exp) begin bad++; $display("FAIL scroll_hex c=%0d got=%h want=%h", c, hex, exp); end
      end
      total++;
      if (tick !== ((c % 4) == 0)) begin bad++; $display("FAIL scroll_tick c=%0d got=%b want=%b", c, tick, ((c % 4) == 0)); end
    end
  endtask

  task automatic test_edge;
    logic [27:0] exp;
    // Write entry 1 on the same edge as the next scroll tick.
    repeat (2) @(negedge ck);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = NEWC;
    @(negedge ck);
    wr_en = 1'b0;
    total++;
    if (tick !== 1'b1) begin bad++; $display("FAIL edge_write_tick got=%b want=1", tick); end
    @(negedge ck);
    exp = {NEWC, code[2], code[3], code[4]};
    total++;
    if (hex !== exp) begin bad++; $display("FAIL edge_write_on_tick got=%h want=%h", hex, exp); end
    repeat (7) @(negedge ck);
    exp = show4(2, 3, 4, 5);
    total++;
    if (hex !== exp) begin bad++; $display("FAIL edge_offset2 got=%h want=%h", hex, exp); end
    // Offset is now 3: switch SCROLL -> BLINK.
    mode = 2'b01;
    @(negedge ck);
    exp = show4(3, 4, 5, 6);
    total++;
    if (hex !== exp) begin bad++; $display("FAIL edge_modechg_old got=%h want=%h", hex, exp); end
    @(negedge ck);
    exp = {code[0], NEWC, code[2], code[3]};
    total++;
    if (hex !== exp) begin bad++; $display("FAIL edge_modechg_show got=%h want=%h", hex, exp); end
    for (int c = 2; c <= 4; c++) begin
      total++;
      if (tick !== 1'b0) begin bad++; $display("FAIL edge_count_clear c=%0d got=%b want=0", c, tick); end
      @(negedge ck);
    end
    total++;
    if (tick !== 1'b1) begin bad++; $display("FAIL edge_first_tick got=%b want=1", tick); end
    @(negedge ck);
    total++;
    if (hex !== ALL_OFF) begin bad++; $display("FAIL edge_blink_blank got=%h want=%h", hex, ALL_OFF); end
  endtask

  task automatic test_range6;
    logic [27:0] exp;
    for (int k = 0; k < 6; k++) begin
      wr_en6 = 1'b1; wr_addr6 = 3'(k); wr_data6 = code[k];
      @(negedge ck);
    end
    wr_addr6 = 3'd6; wr_data6 = 7'h00;
    @(negedge ck);
    wr_addr6 = 3'd7;
    @(negedge ck);
    wr_en6 = 1'b0;
    @(negedge ck);
    total++;
    if (hex6 !== show4(0, 1, 2, 3)) begin bad++; $display("FAIL range_static got=%h want=%h", hex6, show4(0, 1, 2, 3)); end
    mode6 = 2'b10; en6 = 1'b1;
    @(negedge ck);
    for (int c = 1; c <= 25; c++) begin
      @(negedge ck);
      if (c == 13 || c == 21 || c == 25) begin
        exp = (c == 13) ? show4(3, 4, 5, 0) : (c == 21) ? show4(5, 0, 1, 2) : show4(0, 1, 2, 3);
        total++;
        if (hex6 !== exp) begin bad++; $display("FAIL range_scroll c=%0d got=%h want=%h", c, hex6, exp); end
      end
    end
  endtask

  task automatic test_reset_mid;
    mode = 2'b10; en = 1'b1;
    repeat (6) @(negedge ck);
    #1 rs_n = 1'b0;
    #1;
    total++;
    if (hex !== ALL_OFF) begin bad++; $display("FAIL midreset_hex got=%h want=%h", hex, ALL_OFF); end
    total++;
    if (tick !== 1'b0) begin bad++; $display("FAIL midreset_tick got=%b want=0", tick); end
    mode = 2'b00; en = 1'b0; mode6 = 2'b00; en6 = 1'b0;
    @(negedge ck);
    rs_n = 1'b1;
    repeat (2) @(negedge ck);
    total++;
    if (hex !== ALL_OFF) begin bad++; $display("FAIL midreset_buf_lost got=%h want=%h", hex, ALL_OFF); end
    total++;
    if (hex6 !== ALL_OFF) begin bad++; $display("FAIL midreset_buf6_lost got=%h want=%h", hex6, ALL_OFF); end
  endtask

  initial begin
    code[0] = 7'h40; code[1] = 7'h79; code[2] = 7'h24; code[3] = 7'h30;
    code[4] = 7'h19; code[5] = 7'h12; code[6] = 7'h02; code[7] = 7'h78;
    test_reset();
    test_static();
    test_blink();
    test_scroll();
    test_edge();
    test_range6();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
